// File: rtl/sram_fifo_pkg.sv
// Shared defaults and helpers for the SRAM-backed FIFO controller.
// Contents:
//   DEF_* parameter defaults. These match a 128-word x 4-bit 1W1R macro.
//   WMASK_ALL      write mask that enables every bit of a word.
//   RD_LATENCY     edges from a read issue to capturing the data.
//   occ_width()    width of the total-occupancy count.
//   cnt_width()    width needed to count 0..n.
package sram_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;
  localparam int DEF_OBUF_DEPTH = 4;

  localparam logic [DEF_DATA_WIDTH-1:0] WMASK_ALL = '1;

  // The macro registers the read command at the next edge and drives the
  // data at the following negedge. The data is captured one edge after that.
  localparam int RD_LATENCY = 2;

  // The total occupancy is sram + in-flight + buffer.
  // With a buffer of at most DEPTH words, this needs two bits more than an address.
  function automatic int occ_width(input int addr_w);
    return addr_w + 2;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// A small circular register FIFO. It serves as the first-word-fall-through
// output buffer of the SRAM FIFO controller.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   push_i            append push_data_i. The caller never pushes while full.
//   push_data_i       data to append
//   pop_i             drop the head word. Only honoured when valid_o is 1.
//   valid_o           the buffer holds at least one word
//   head_o            head word. Holds the last popped word while empty.
//   count_o           number of stored words
// A push and a pop at the same edge are both honoured.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
#(
  parameter int DW    = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_OBUF_DEPTH,
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [DW-1:0] head_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] last_q;
  logic          do_pop;

  // DEPTH need not be a power of two, so the index wraps explicitly.
  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
    return (i == IW'(DEPTH - 1)) ? '0 : i + IW'(1);
  endfunction

  assign valid_o = (cnt_q != '0);
  assign do_pop  = pop_i && valid_o;
  assign count_o = cnt_q;
  // While the buffer is empty, show the last word that left it. A stale
  // slot would not be the last value.
  assign head_o  = valid_o ? mem_q[rd_idx_q] : last_q;

  always_comb begin
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    cnt_d    = cnt_q;
    if (push_i) wr_idx_d = idx_inc(wr_idx_q);
    if (do_pop) rd_idx_d = idx_inc(rd_idx_q);
    case ({push_i, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
      if (do_pop) last_q <= mem_q[rd_idx_q];
    end
  end

  // Storage needs no reset, because occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_idx_q] <= push_data_i;
  end

endmodule

// File: rtl/sram_fifo_ctrl_128x4.sv
// A FIFO controller for one 128x4 1W1R SRAM macro. The macro has registered
// inputs and is accessed on the negedge.
// Ports:
//   clk, rst_n                 clock, which also drives the macro clocks.
//                              Asynchronous active-low reset.
//   in_valid/in_ready/in_data  push handshake
//   out_valid/out_ready/out_data
//                              first-word-fall-through pop handshake
//   count                      total occupancy: sram + in-flight reads + buffer
//   sram_csb0/wmask0/addr0/din0
//                              registered macro write port
//   sram_csb1/addr1            registered macro read port
//   sram_dout1                 macro read data
// A read issued at edge M returns at edge M+2 into a small output buffer.
// Issue is throttled so buffer plus in-flight never exceeds the buffer size.
module sram_fifo_ctrl_128x4
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int OBUF_DEPTH = DEF_OBUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  sram_csb0,
  output logic [DATA_WIDTH-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int CW  = occ_width(ADDR_WIDTH);
  localparam int SCW = ADDR_WIDTH + 1;
  localparam int OCW = cnt_width(OBUF_DEPTH);
  localparam int PW  = cnt_width(OBUF_DEPTH + RD_LATENCY) + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [SCW-1:0]        sram_cnt_q, sram_cnt_d;
  logic                  fly1_q, fly2_q;
  logic                  csb0_q, csb1_q;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;

  logic                  push_acc, pop, issue;
  logic [OCW-1:0]        obuf_cnt;
  logic [PW-1:0]         pending;

  assign in_ready = (sram_cnt_q != SCW'(DEPTH));
  assign push_acc = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Words already committed toward the buffer. A pop at this edge frees a
  // slot in time for a read issued now, which gives one pop per cycle.
  assign pending  = PW'(obuf_cnt) + PW'(fly1_q) + PW'(fly2_q);
  assign issue    = (sram_cnt_q != '0) && (pending < PW'(OBUF_DEPTH) + PW'(pop));

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sram_cnt_d = sram_cnt_q;
    addr0_d    = addr0_q;
    din0_d     = din0_q;
    addr1_d    = addr1_q;
    if (push_acc) begin
      addr0_d  = wr_ptr_q;
      din0_d   = in_data;
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (issue) begin
      addr1_d  = rd_ptr_q;
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    case ({push_acc, issue})
      2'b10:   sram_cnt_d = sram_cnt_q + SCW'(1);
      2'b01:   sram_cnt_d = sram_cnt_q - SCW'(1);
      default: sram_cnt_d = sram_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      fly1_q     <= 1'b0;
      fly2_q     <= 1'b0;
      csb0_q     <= 1'b1;
      csb1_q     <= 1'b1;
      addr0_q    <= '0;
      din0_q     <= '0;
      addr1_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      fly1_q     <= issue;
      fly2_q     <= fly1_q;
      csb0_q     <= !push_acc;
      csb1_q     <= !issue;
      addr0_q    <= addr0_d;
      din0_q     <= din0_d;
      addr1_q    <= addr1_d;
    end
  end

  assign sram_csb0   = csb0_q;
  assign sram_wmask0 = WMASK_ALL;
  assign sram_addr0  = addr0_q;
  assign sram_din0   = din0_q;
  assign sram_csb1   = csb1_q;
  assign sram_addr1  = addr1_q;

  // The second in-flight stage marks the edge at which the macro output is
  // valid. That output is sampled right at this edge, before the macro lets it go.
  sram_fifo_obuf #(
    .DW    (DATA_WIDTH),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fly2_q),
    .push_data_i (sram_dout1),
    .pop_i       (pop),
    .valid_o     (out_valid),
    .head_o      (out_data),
    .count_o     (obuf_cnt)
  );

  assign count = CW'(sram_cnt_q) + CW'(fly1_q) + CW'(fly2_q) + CW'(obuf_cnt);

`ifndef SYNTHESIS
  // Writing and reading one address together would need sram_cnt at 0 or full.
  // Neither can produce both commands.
  a_no_addr_collision: assert property (@(posedge clk) disable iff (!rst_n)
    !(!sram_csb0 && !sram_csb1 && (sram_addr0 == sram_addr1)));
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl_128x4.sv
module tb_sram_fifo_ctrl_128x4;
  localparam int DW = 4;
  localparam int AW = 7;
  localparam int DEPTH = 128;
  localparam int OBUF = 4;
  localparam int CW = AW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          sram_csb0, sram_csb1;
  logic [DW-1:0] sram_wmask0, sram_din0;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_dout1 = '0;

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;
  logic [DW-1:0] exp_q[$];

  sram_fifo_ctrl_128x4 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
    .sram_dout1(sram_dout1)
  );

  always #5 clk = ~clk;

  // Behavioural 1W1R macro. Inputs are latched at posedge and the access
  // happens at negedge. The read data goes to junk shortly after the next posedge.
  logic [DW-1:0] mem [DEPTH];
  logic          w_l = 1'b0, r_l = 1'b0;
  logic [AW-1:0] wa_l = '0, ra_l = '0;
  logic [DW-1:0] wd_l = '0;

  always @(posedge clk) begin
    w_l  <= !sram_csb0 && (sram_wmask0 == '1);
    wa_l <= sram_addr0;
    wd_l <= sram_din0;
    r_l  <= !sram_csb1;
    ra_l <= sram_addr1;
  end

  always begin
    @(posedge clk);
    #1 sram_dout1 = DW'($urandom);
    @(negedge clk);
    if (w_l) mem[wa_l] = wd_l;
    if (r_l) sram_dout1 = mem[ra_l];
  end

  // Scoreboard monitor: accepted pushes are queued and every pop is checked.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_vec++;
        n_pop++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pop_data: got %h, expected nothing (queue empty)", out_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_err++;
            $display("FAIL pop_data #%0d: got %h, expected %h", n_pop, out_data, e);
          end else begin
            $display("pop #%0d data=%h ok", n_pop, out_data);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  // The occupancy must track the reference queue. in_ready may only drop when
  // at least DEPTH words are held.
  always @(negedge clk) begin
    if (rst_n) begin
      n_vec++;
      if (count !== CW'(exp_q.size())) begin
        n_err++;
        $display("FAIL count: got %0d, expected %0d", count, exp_q.size());
      end
      n_vec++;
      if ((!in_ready && exp_q.size() < DEPTH) || exp_q.size() > DEPTH + OBUF) begin
        n_err++;
        $display("FAIL ready_vs_occ: in_ready=%0b, expected 1 with occupancy %0d", in_ready, exp_q.size());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (count != '0 && k < budget) begin
      step();
      k++;
    end
    chk({name, "_drained"}, 32'(count), 0);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, bubbles;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_csb0", sram_csb0, 1);
    chk("rst_csb1", sram_csb1, 1);
    chk("rst_count", count, 0);
    chk("rst_addr0", sram_addr0, 0);
    chk("rst_din0", sram_din0, 0);
    chk("rst_addr1", sram_addr1, 0);
    chk("wmask", sram_wmask0, 4'hF);
    rst_n = 1'b1;

    // A single push of A at edge 1 comes out after edge 4.
    in_valid = 1'b1;
    in_data  = 4'hA;
    step();
    in_valid = 1'b0;
    chk("e1_csb0", sram_csb0, 0);
    chk("e1_addr0", sram_addr0, 0);
    chk("e1_din0", sram_din0, 4'hA);
    step();
    chk("e2_csb1", sram_csb1, 0);
    chk("e2_addr1", sram_addr1, 0);
    chk("e2_csb0", sram_csb0, 1);
    step();
    chk("e3_out_valid", out_valid, 0);
    step();
    chk("e4_out_valid", out_valid, 1);
    chk("e4_out_data", out_data, 4'hA);
    chk("e4_count", count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("e5_empty", out_valid, 0);
    chk("e5_hold_data", out_data, 4'hA);

    // Fill with out_ready low. The buffer plus the SRAM absorb DEPTH+OBUF words.
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 140; i++) begin
      in_data = DW'(acc);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("fill_accepted", acc, DEPTH + OBUF);
    chk("fill_count", count, DEPTH + OBUF);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_csb1_idle", sram_csb1, 1);
    chk("fill_out_valid", out_valid, 1);

    // Drain a full FIFO at one word per cycle, with no bubbles.
    out_ready = 1'b1;
    bubbles = 0;
    for (int i = 0; i < DEPTH + OBUF; i++) begin
      if (!out_valid) bubbles++;
      step();
      if (i == 0) chk("drain_in_ready", in_ready, 1);
    end
    chk("drain_bubbles", bubbles, 0);
    chk("drain_empty", out_valid, 0);
    chk("drain_count", count, 0);

    // Stream through the pointer wrap at full throughput.
    in_valid = 1'b1;
    bubbles = 0;
    for (int i = 0; i < 300; i++) begin
      in_data = DW'(i);
      if (i >= 5 && !out_valid) bubbles++;
      if (!in_ready) bubbles++;
      step();
    end
    chk("stream_bubbles", bubbles, 0);
    drain("stream", 50);

    // Random handshakes
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_data   = DW'($urandom);
      step();
    end
    drain("random", 400);

    // Reset in the middle of a run with 20 words stored.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = DW'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("mid_count", count, 20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_csb0", sram_csb0, 1);
    chk("mid_rst_csb1", sram_csb1, 1);
    chk("mid_rst_count", count, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'h5;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("post_rst_e2_out_valid", out_valid, 0);
    step();
    chk("post_rst_e3_out_valid", out_valid, 1);
    chk("post_rst_e3_out_data", out_data, 4'h5);
    step();
    chk("post_rst_done", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
